// File: rtl/dump_sequencer.sv
// Streams PC, cycle count, register bank and data memory out over a byte UART, MSB first.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module dump_sequencer #(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int N_MEM   = 128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_cycles,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic [4:0]         o_reg_addr,
  output logic               o_reg_rd,
  output logic [6:0]         o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_busy,
  output logic               o_done
);

  localparam int N_WORDS  = 2 + N_REGS + N_MEM;
  localparam int LAST_IDX = N_WORDS - 1;
  localparam int IDX_W    = $clog2(N_WORDS);
  localparam int NB_BYTES = NB_DATA / 8;
  localparam int BYTE_W   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int REG_BASE = 2;
  localparam int MEM_BASE = 2 + N_REGS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_FINISH
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]   index_reg;
  logic [BYTE_W-1:0]  byte_reg;
  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] pc_snap_reg;
  logic [NB_DATA-1:0] cyc_snap_reg;
  logic [NB_DATA-1:0] word_sel;
  logic               is_reg;
  logic               is_mem;
  logic               last_word;
  logic               last_byte;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       csum_phase_reg;
`endif

  assign is_reg    = (index_reg >= IDX_W'(REG_BASE)) && (index_reg < IDX_W'(MEM_BASE));
  assign is_mem    = (index_reg >= IDX_W'(MEM_BASE));
  assign last_word = (index_reg == IDX_W'(LAST_IDX));
  assign last_byte = (byte_reg == BYTE_W'(NB_BYTES - 1));

  // Read data arrives the cycle after the strobe, i.e. while in CAPTURE.
  always_comb begin
    word_sel = i_mem_data;
    if (index_reg == IDX_W'(0)) begin
      word_sel = pc_snap_reg;
    end else if (index_reg == IDX_W'(1)) begin
      word_sel = cyc_snap_reg;
    end else if (is_reg) begin
      word_sel = i_reg_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (i_start) state_next = S_READ;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SEND;
      S_SEND:    state_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
          if (csum_phase_reg)  state_next = S_FINISH;
          else if (!last_byte) state_next = S_SEND;
          else if (!last_word) state_next = S_READ;
          else                 state_next = S_SEND;
`else
          if (!last_byte)      state_next = S_SEND;
          else if (!last_word) state_next = S_READ;
          else                 state_next = S_FINISH;
`endif
        end
      end
      S_FINISH:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = (state_reg == S_SEND);
    o_tx_data  = shift_reg[NB_DATA-1 -: 8];
    o_reg_rd   = (state_reg == S_READ) && is_reg;
    o_mem_rd   = (state_reg == S_READ) && is_mem;
    o_reg_addr = '0;
    o_mem_addr = '0;
    if (o_reg_rd) o_reg_addr = 5'(index_reg - IDX_W'(REG_BASE));
    if (o_mem_rd) o_mem_addr = 7'(index_reg - IDX_W'(MEM_BASE));
    o_busy     = (state_reg != S_IDLE);
    o_done     = (state_reg == S_FINISH);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      index_reg      <= '0;
      byte_reg       <= '0;
      shift_reg      <= '0;
      pc_snap_reg    <= '0;
      cyc_snap_reg   <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_reg       <= '0;
      csum_phase_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            pc_snap_reg    <= i_pc;
            cyc_snap_reg   <= i_cycles;
            index_reg      <= '0;
            byte_reg       <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_reg       <= '0;
            csum_phase_reg <= 1'b0;
`endif
          end
        end
        S_CAPTURE: shift_reg <= word_sel;
`ifdef DUMP_CHECKSUM_EN
        S_SEND: begin
          if (!csum_phase_reg) csum_reg <= csum_reg ^ shift_reg[NB_DATA-1 -: 8];
        end
`endif
        S_WAIT_TX: begin
`ifdef DUMP_CHECKSUM_EN
          if (i_tx_done && !csum_phase_reg) begin
`else
          if (i_tx_done) begin
`endif
            if (!last_byte) begin
              byte_reg  <= byte_reg + BYTE_W'(1);
              shift_reg <= {shift_reg[NB_DATA-9:0], 8'h00};
            end else begin
              byte_reg <= '0;
              // Terminal index is held rather than wrapped.
              if (!last_word) begin
                index_reg <= index_reg + IDX_W'(1);
              end
`ifdef DUMP_CHECKSUM_EN
              else begin
                csum_phase_reg <= 1'b1;
                shift_reg      <= {csum_reg, {(NB_DATA-8){1'b0}}};
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: expected byte stream is built from the dump
// rules and checked by a monitor against every o_tx_start.
module tb_dump_sequencer;

  localparam int NB_DATA = 32;
  localparam int N_REGS  = 32;
  localparam int N_MEM   = 128;
`ifdef DUMP_CHECKSUM_EN
  localparam int DUMP_BYTES = 649;
`else
  localparam int DUMP_BYTES = 648;
`endif

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic              i_start;
  logic [NB_DATA-1:0] i_pc;
  logic [NB_DATA-1:0] i_cycles;
  logic [NB_DATA-1:0] i_reg_data = '0;
  logic [NB_DATA-1:0] i_mem_data = '0;
  logic              uart_done;
  logic              spur_done;
  logic              i_tx_done;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic [4:0]        o_reg_addr;
  logic              o_reg_rd;
  logic [6:0]        o_mem_addr;
  logic              o_mem_rd;
  logic              o_busy;
  logic              o_done;

  assign i_tx_done = uart_done | spur_done;

  dump_sequencer #(.NB_DATA(NB_DATA), .N_REGS(N_REGS), .N_MEM(N_MEM)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_pc       (i_pc),
    .i_cycles   (i_cycles),
    .i_reg_data (i_reg_data),
    .i_mem_data (i_mem_data),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_reg_addr (o_reg_addr),
    .o_reg_rd   (o_reg_rd),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clock = ~i_clock;

  logic [NB_DATA-1:0] reg_mem [N_REGS];
  logic [NB_DATA-1:0] data_mem [N_MEM];

  // Register bank and data memory with one-cycle registered read.
  always @(posedge i_clock) begin
    if (o_reg_rd) i_reg_data <= reg_mem[o_reg_addr];
    if (o_mem_rd) i_mem_data <= data_mem[o_mem_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  int sent_cnt = 0;
  int reg_rd_cnt = 0;
  int mem_rd_cnt = 0;
  int reg5_hits = 0;
  int done_cnt = 0;
  int tx_start_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte per o_tx_start, tracks read strobes and completion.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge i_clock);
      if (o_tx_start) begin
        tx_start_total++;
        sent_cnt++;
        chk("tx_start_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", sent_cnt - 1), o_tx_data, e);
          $display("byte %0d: 0x%02h (exp 0x%02h)", sent_cnt - 1, o_tx_data, e);
        end
      end
      if (o_reg_rd) begin
        chk("reg_addr", o_reg_addr, reg_rd_cnt);
        if (o_reg_addr == 5'd5) reg5_hits++;
        reg_rd_cnt++;
      end
      if (o_mem_rd) begin
        chk("mem_addr", o_mem_addr, mem_rd_cnt);
        mem_rd_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        chk("done_byte_count", sent_cnt, DUMP_BYTES);
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_reg_reads", reg_rd_cnt, N_REGS);
        chk("done_mem_reads", mem_rd_cnt, N_MEM);
      end
    end
  end

  // UART model: answers each o_tx_start with a done pulse after a random delay,
  // checking that the data byte stays put until then.
  initial begin
    bit pending;
    int cd;
    logic [7:0] held;
    pending = 0;
    cd = 0;
    held = '0;
    uart_done = 1'b0;
    forever begin
      @(negedge i_clock);
      uart_done = 1'b0;
      if (i_reset) begin
        pending = 0;
      end else if (pending) begin
        if (cd == 0) begin
          chk("tx_data_stable", o_tx_data, held);
          uart_done = 1'b1;
          pending = 0;
        end else begin
          cd--;
        end
      end else if (o_tx_start) begin
        pending = 1;
        held = o_tx_data;
        cd = $urandom_range(0, 2);
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < N_REGS; i++) reg_mem[i] = $urandom;
    for (int i = 0; i < N_MEM; i++) data_mem[i] = $urandom;
  endtask

  // Reference stream: PC, cycles, registers, memory, each word big-endian.
  task automatic build_expected(input logic [31:0] pc, input logic [31:0] cyc);
    logic [31:0] words [$];
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  cs;
    exp_q.delete();
    words.delete();
    words.push_back(pc);
    words.push_back(cyc);
    for (int i = 0; i < N_REGS; i++) words.push_back(reg_mem[i]);
    for (int i = 0; i < N_MEM; i++) words.push_back(data_mem[i]);
    cs = 8'h00;
    foreach (words[k]) begin
      w = words[k];
      for (int j = 3; j >= 0; j--) begin
        b = w[8*j +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic start_dump(input logic [31:0] pc, input logic [31:0] cyc);
    int n;
    sent_cnt = 0;
    reg_rd_cnt = 0;
    mem_rd_cnt = 0;
    reg5_hits = 0;
    build_expected(pc, cyc);
    @(negedge i_clock);
    i_pc = pc;
    i_cycles = cyc;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    i_pc = $urandom;
    i_cycles = $urandom;
    chk("busy_after_start", o_busy, 1);
    n = 1;
    while (!o_tx_start && n < 10) begin
      @(negedge i_clock);
      n++;
    end
    chk("first_tx_latency", n, 3);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (sent_cnt < target && n < 5000) begin
      @(negedge i_clock);
      n++;
    end
    chk("bytes_reached", sent_cnt >= target, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_done && n < 20000) begin
      @(negedge i_clock);
      n++;
    end
    chk("done_seen", o_done, 1);
    @(negedge i_clock);
    chk("idle_after_done", o_busy, 0);
    chk("done_single_cycle", o_done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_tx_start"}, o_tx_start, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_reg_rd"}, o_reg_rd, 0);
    chk({tag, "_reg_addr"}, o_reg_addr, 0);
    chk({tag, "_mem_rd"}, o_mem_rd, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    i_reset = 1'b1;
    i_start = 1'b0;
    spur_done = 1'b0;
    i_pc = '0;
    i_cycles = '0;
    repeat (3) @(negedge i_clock);
    check_all_zero("reset");
    i_reset = 1'b0;

    // Spurious tx_done while idle must do nothing.
    @(negedge i_clock);
    spur_done = 1'b1;
    @(negedge i_clock);
    spur_done = 1'b0;
    repeat (5) @(negedge i_clock);
    chk("idle_spurious_busy", o_busy, 0);
    chk("idle_spurious_tx", tx_start_total, 0);

    // Dump 1: PC=3, cycles=4, reg5 and mem127 marked; restart attempt mid-dump.
    fill_random();
    reg_mem[5] = 32'hDEADBEEF;
    data_mem[127] = 32'h01020304;
    start_dump(32'h00000003, 32'h00000004);
    wait_bytes(50);
    @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    wait_done();
    chk("reg5_read_once", reg5_hits, 1);
    chk("done_count_1", done_cnt, 1);

    starts = tx_start_total;
    spur_done = 1'b1;
    @(negedge i_clock);
    spur_done = 1'b0;
    repeat (20) @(negedge i_clock);
    chk("no_tx_after_spurious", tx_start_total, starts);

    // Dump 2: random data, aborted by reset after byte 100.
    fill_random();
    start_dump($urandom, $urandom);
    wait_bytes(100);
    #2;
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    starts = tx_start_total;
    repeat (40) @(negedge i_clock);
    chk("no_tx_after_abort", tx_start_total, starts);
    chk("idle_after_abort", o_busy, 0);

    // Dump 3: restart after abort, full random dump.
    fill_random();
    start_dump($urandom, $urandom);
    wait_done();

    // Dump 4: all data zero except PC=3.
    for (int i = 0; i < N_REGS; i++) reg_mem[i] = '0;
    for (int i = 0; i < N_MEM; i++) data_mem[i] = '0;
    start_dump(32'h00000003, 32'h00000000);
    wait_done();
    chk("done_count_total", done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
